// File: rtl/full_adder_pkg.sv
// full_adder_pkg: shared constants and types for the registered ripple adder.
//   FA_MAX_WIDTH : widest legal operand width
//   fa_result_t  : {carry, sum} result record, sized for the widest adder
//   fa_width_ok  : elaboration-time legality check for a WIDTH value
package full_adder_pkg;

  localparam int FA_MAX_WIDTH = 64;

  typedef struct packed {
    logic                    carry;
    logic [FA_MAX_WIDTH-1:0] sum;
  } fa_result_t;

  function automatic bit fa_width_ok(input int w);
    return (w >= 1) && (w <= FA_MAX_WIDTH);
  endfunction

endpackage

// File: rtl/full_adder_bit.sv
// full_adder_bit: purely combinational one-bit full-adder cell.
//   a_i, b_i  : operand bits
//   cin_i     : carry in
//   s_o       : sum bit
//   cout_o    : carry out (majority of the three inputs)
module full_adder_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  assign s_o    = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/full_adder_unit.sv
// full_adder_unit: registered WIDTH-bit adder built from a ripple chain of
// full_adder_bit cells. Result appears one clock after the operands are
// sampled; one operand set accepted every cycle, no backpressure.
//   clk, rst           : clock, asynchronous active-high reset
//   in_valid           : operands valid this cycle (loads the result register)
//   input_a, input_b   : unsigned operands
//   carry_in           : carry into bit 0
//   out_valid          : in_valid delayed one cycle
//   sum, carry_out     : registered {carry_out, sum} = a + b + carry_in
//   overflow           : registered two's-complement overflow, only present
//                        when FULL_ADDER_OVERFLOW_EN is defined
module full_adder_unit
  import full_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  input  logic             carry_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
`ifdef FULL_ADDER_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  if (!fa_width_ok(WIDTH)) begin : g_bad_width
    $error("full_adder_unit: WIDTH out of range");
  end

  // c[i] is the carry into bit i; c[WIDTH] is the carry out of the chain.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_d;

  assign c[0] = carry_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder_bit u_bit (
      .a_i   (input_a[i]),
      .b_i   (input_b[i]),
      .cin_i (c[i]),
      .s_o   (sum_d[i]),
      .cout_o(c[i+1])
    );
  end

  logic             vld_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;

  // Data registers only load on valid so the last result stays visible
  // while the stream idles; the valid flag itself follows in_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q   <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) begin
        sum_q   <= sum_d;
        carry_q <= c[WIDTH];
      end
    end
  end

  assign out_valid = vld_q;
  assign sum       = sum_q;
  assign carry_out = carry_q;

`ifdef FULL_ADDER_OVERFLOW_EN
  // Signed overflow: carry into the sign bit differs from carry out of it.
  // With WIDTH = 1 the carry into the sign bit is carry_in itself.
  logic ovf_d;
  logic ovf_q;

  assign ovf_d = c[WIDTH] ^ c[WIDTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           ovf_q <= 1'b0;
    else if (in_valid) ovf_q <= ovf_d;
  end

  assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_full_adder_unit.sv
// Bench for full_adder_unit: three instances (WIDTH 1, 8, 16) share one
// stimulus stream. Expected results are queued when a vector is driven and
// popped one cycle later when the result is due.
module tb_full_adder_unit;
  import full_adder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, vld, cin;
  logic [15:0] a, b;

  logic        v1, v8, v16;
  logic [0:0]  s1;
  logic [7:0]  s8;
  logic [15:0] s16;
  logic        c1, c8, c16;
`ifdef FULL_ADDER_OVERFLOW_EN
  logic        o1, o8, o16;
`endif

  full_adder_unit #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(vld), .input_a(a[0:0]), .input_b(b[0:0]),
    .carry_in(cin), .out_valid(v1), .sum(s1), .carry_out(c1)
`ifdef FULL_ADDER_OVERFLOW_EN
    , .overflow(o1)
`endif
  );

  full_adder_unit #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(vld), .input_a(a[7:0]), .input_b(b[7:0]),
    .carry_in(cin), .out_valid(v8), .sum(s8), .carry_out(c8)
`ifdef FULL_ADDER_OVERFLOW_EN
    , .overflow(o8)
`endif
  );

  full_adder_unit #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .in_valid(vld), .input_a(a), .input_b(b),
    .carry_in(cin), .out_valid(v16), .sum(s16), .carry_out(c16)
`ifdef FULL_ADDER_OVERFLOW_EN
    , .overflow(o16)
`endif
  );

  // ov[0]=W1, ov[1]=W8, ov[2]=W16
  typedef struct packed {
    logic        vld;
    logic [1:0]  e1;
    logic [8:0]  e8;
    logic [16:0] e16;
    logic [2:0]  ov;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    exp_t        e;
  } vec_t;

  int     checks = 0;
  int     errors = 0;
  exp_t   q[$];
  exp_t   last;
  vec_t   tbl[13];
  fa_result_t r16;

  function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endfunction

  function automatic logic ovf_model(input int w, input logic [15:0] aa, input logic [15:0] bb,
                                     input logic ci);
    logic [16:0] m, m2, full, lo;
    m    = (17'd1 << w) - 17'd1;
    m2   = (17'd1 << (w - 1)) - 17'd1;
    full = ({1'b0, aa} & m)  + ({1'b0, bb} & m)  + 17'(ci);
    lo   = ({1'b0, aa} & m2) + ({1'b0, bb} & m2) + 17'(ci);
    return full[w] ^ lo[w-1];
  endfunction

  function automatic exp_t model(input logic v, input logic [15:0] aa, input logic [15:0] bb,
                                 input logic ci);
    exp_t r;
    r = last;
    r.vld = v;
    if (v) begin
      r.e1  = 2'({1'b0, aa[0]}) + 2'({1'b0, bb[0]}) + 2'(ci);
      r.e8  = {1'b0, aa[7:0]} + {1'b0, bb[7:0]} + 9'(ci);
      r16   = '0;
      {r16.carry, r16.sum[15:0]} = {1'b0, aa} + {1'b0, bb} + 17'(ci);
      r.e16 = {r16.carry, r16.sum[15:0]};
      r.ov  = {ovf_model(16, aa, bb, ci), ovf_model(8, aa, bb, ci), ovf_model(1, aa, bb, ci)};
    end
    return r;
  endfunction

  task automatic check_out();
    exp_t e;
    if (q.size() == 0) return;
    e = q.pop_front();
    chk("vld_w1",  v1,  e.vld);
    chk("vld_w8",  v8,  e.vld);
    chk("vld_w16", v16, e.vld);
    chk("res_w1",  {c1, s1},   e.e1);
    chk("res_w8",  {c8, s8},   e.e8);
    chk("res_w16", {c16, s16}, e.e16);
`ifdef FULL_ADDER_OVERFLOW_EN
    chk("ovf_w1",  o1,  e.ov[0]);
    chk("ovf_w8",  o8,  e.ov[1]);
    chk("ovf_w16", o16, e.ov[2]);
`endif
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_vld"}, {v1, v8, v16}, 3'b000);
    chk({nm, "_w1"},  {c1, s1}, 2'b00);
    chk({nm, "_w8"},  {c8, s8}, 9'h0);
    chk({nm, "_w16"}, {c16, s16}, 17'h0);
`ifdef FULL_ADDER_OVERFLOW_EN
    chk({nm, "_ovf"}, {o1, o8, o16}, 3'b000);
`endif
  endtask

  task automatic do_step(input logic v, input logic [15:0] aa, input logic [15:0] bb,
                         input logic ci, input exp_t e);
    @(negedge clk);
    check_out();
    vld = v; a = aa; b = bb; cin = ci;
    q.push_back(e);
    last = e;
  endtask

  task automatic step_model(input logic v, input logic [15:0] aa, input logic [15:0] bb,
                            input logic ci);
    do_step(v, aa, bb, ci, model(v, aa, bb, ci));
  endtask

  initial begin
    // {a, b, cin, {vld, e1, e8, e16, ov16/ov8/ov1}}
    tbl[0]  = '{16'h0000, 16'h0000, 1'b0, '{1'b1, 2'b00, 9'h000, 17'h00000, 3'b000}};
    tbl[1]  = '{16'h0000, 16'h0001, 1'b0, '{1'b1, 2'b01, 9'h001, 17'h00001, 3'b000}};
    tbl[2]  = '{16'h0001, 16'h0001, 1'b0, '{1'b1, 2'b10, 9'h002, 17'h00002, 3'b001}};
    tbl[3]  = '{16'h0001, 16'h0000, 1'b0, '{1'b1, 2'b01, 9'h001, 17'h00001, 3'b000}};
    tbl[4]  = '{16'h0000, 16'h0000, 1'b1, '{1'b1, 2'b01, 9'h001, 17'h00001, 3'b001}};
    tbl[5]  = '{16'h0000, 16'h0001, 1'b1, '{1'b1, 2'b10, 9'h002, 17'h00002, 3'b000}};
    tbl[6]  = '{16'h0001, 16'h0001, 1'b1, '{1'b1, 2'b11, 9'h003, 17'h00003, 3'b000}};
    tbl[7]  = '{16'h0001, 16'h0000, 1'b1, '{1'b1, 2'b10, 9'h002, 17'h00002, 3'b000}};
    tbl[8]  = '{16'h00FF, 16'h0001, 1'b0, '{1'b1, 2'b10, 9'h100, 17'h00100, 3'b001}};
    tbl[9]  = '{16'h007F, 16'h0000, 1'b1, '{1'b1, 2'b10, 9'h080, 17'h00080, 3'b010}};
    tbl[10] = '{16'hFFFF, 16'hFFFF, 1'b1, '{1'b1, 2'b11, 9'h1FF, 17'h1FFFF, 3'b000}};
    tbl[11] = '{16'h8000, 16'h8000, 1'b0, '{1'b1, 2'b00, 9'h000, 17'h10000, 3'b100}};
    tbl[12] = '{16'h0003, 16'h0004, 1'b0, '{1'b1, 2'b01, 9'h007, 17'h00007, 3'b000}};

    // Reset held with valid operands present: outputs stay cleared.
    rst = 1'b1; vld = 1'b1; a = 16'h1; b = 16'h1; cin = 1'b0;
    last = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    rst = 1'b0; vld = 1'b0;

    // Truth table, carry/overflow boundaries, then 3+4 followed by a hold.
    for (int i = 0; i < 13; i++) do_step(1'b1, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].e);
    for (int i = 0; i < 3; i++)
      step_model(1'b0, 16'($urandom), 16'($urandom), 1'($urandom));

    // Reset mid-stream discards the in-flight result.
    step_model(1'b1, 16'h1234, 16'h4321, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset("midreset_async");
    q.delete();
    last = '0;
    @(negedge clk);
    check_reset("midreset_held");
    rst = 1'b0;

    // Back-to-back random traffic, then random gaps.
    for (int i = 0; i < 10000; i++)
      step_model(1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
    for (int i = 0; i < 300; i++)
      step_model(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1'($urandom));

    @(negedge clk);
    check_out();
    vld = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
